// File: rtl/sub_div_ctrl.sv
// Restoring 4-bit divider sequencer that borrows an external combinational subtractor.
// Results and done register one edge after the DONE state; start is ignored while busy.
module sub_div_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic [3:0] sub_a,
  output logic [3:0] sub_b,
  input  logic [3:0] sub_diff,
  input  logic       sub_borrow,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     state, state_nxt;
  logic [3:0] q_q, r_q, d_q;
  logic [1:0] cnt;
  logic [3:0] low;
  logic       take;

  always_comb begin
    state_nxt = state;
    sub_a     = 4'h0;
    sub_b     = 4'h0;
    low       = {r_q[2:0], q_q[3]};
    take      = r_q[3] | ~sub_borrow;
    case (state)
      S_IDLE: if (start) state_nxt = (divisor == 4'h0) ? S_DONE : S_RUN;
      S_RUN: begin
        sub_a = low;
        sub_b = d_q;
        if (cnt == 2'd3) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      q_q         <= 4'h0;
      r_q         <= 4'h0;
      d_q         <= 4'h0;
      cnt         <= 2'd0;
      done        <= 1'b0;
      quotient    <= 4'h0;
      remainder   <= 4'h0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          d_q         <= divisor;
          q_q         <= dividend;
          r_q         <= 4'h0;
          cnt         <= 2'd0;
          div_by_zero <= 1'b0;
        end
        S_RUN: begin
          r_q <= take ? sub_diff : low;
          q_q <= {q_q[2:0], take};
          cnt <= cnt + 2'd1;
        end
        S_DONE: begin
          // A zero divisor skipped RUN, so q_q still holds the untouched dividend.
          if (d_q == 4'h0) begin
            quotient    <= 4'hF;
            remainder   <= q_q;
            div_by_zero <= 1'b1;
          end else begin
            quotient  <= q_q;
            remainder <= r_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_div_ctrl.sv
// Bench for sub_div_ctrl: directed table, hand-written corner sequences, exhaustive and random ops.
module tb_sub_div_ctrl;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] dividend, divisor, sub_a, sub_b, sub_diff;
  logic       sub_borrow, busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  int errors = 0;
  int checks = 0;
  logic [3:0] last_q = 4'h0, last_r = 4'h0;
  logic       last_dz = 1'b0;

  always #5 clk = ~clk;

  assign sub_diff   = sub_a - sub_b;
  assign sub_borrow = (sub_a < sub_b);

  sub_div_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .sub_a(sub_a), .sub_b(sub_b), .sub_diff(sub_diff), .sub_borrow(sub_borrow),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Minuend presented in iteration i of long division: previous partial remainder doubled plus next dividend bit.
  function automatic logic [3:0] low_exp(input int a, input int b, input int i);
    int p;
    p = (((a >> (4 - i)) % b) * 2) + ((a >> (3 - i)) & 1);
    return p[3:0];
  endfunction

  task automatic idle_chk(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); @(negedge clk);
      chk("idle_done", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("hold_q", quotient, last_q);
      chk("hold_r", remainder, last_r);
      chk("hold_dz", div_by_zero, last_dz);
    end
  endtask

  // Called on a negedge with the DUT idle; returns on the negedge where done is high.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit poke);
    logic [3:0] eq, er;
    bit z;
    int lat;
    z   = (b == 4'h0);
    eq  = z ? 4'hF : 4'(int'(a) / int'(b));
    er  = z ? a : 4'(int'(a) % int'(b));
    lat = z ? 1 : 5;
    dividend = a; divisor = b; start = 1'b1;
    for (int c = 0; c <= lat; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 0) start = 1'b0;
      if (poke && c == 1) begin start = 1'b1; dividend = 4'd9; divisor = 4'd2; end
      if (poke && c == 2) begin start = 1'b0; dividend = 4'd1; divisor = 4'd0; end
      if (c < lat - 1) begin
        chk("run_busy", busy, 1'b1);
        chk("run_sub_a", sub_a, low_exp(int'(a), int'(b), c));
        chk("run_sub_b", sub_b, b);
        chk("run_done", done, 1'b0);
      end else if (c == lat - 1) begin
        chk("done_st_busy", busy, 1'b1);
        chk("done_st_sub_a", sub_a, 4'h0);
        chk("done_st_sub_b", sub_b, 4'h0);
        chk("done_st_done", done, 1'b0);
      end else begin
        chk("done_pulse", done, 1'b1);
        chk("done_busy", busy, 1'b0);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, z);
        chk("idle_sub_a", sub_a, 4'h0);
        chk("idle_sub_b", sub_b, 4'h0);
      end
    end
    last_q = eq; last_r = er; last_dz = z;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
    vecs[2] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
    vecs[3] = '{4'd3,  4'd9,  4'd0,  4'd3, 1'b0};
    vecs[4] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
    vecs[5] = '{4'd7,  4'd0,  4'hF,  4'd7, 1'b1};
    vecs[6] = '{4'd8,  4'd3,  4'd2,  4'd2, 1'b0};
    vecs[7] = '{4'd10, 4'd3,  4'd3,  4'd1, 1'b0};

    rst = 1'b1; start = 1'b0; dividend = 4'h0; divisor = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", quotient, 4'h0);
    chk("rst_r", remainder, 4'h0);
    chk("rst_dz", div_by_zero, 1'b0);
    chk("rst_sub_a", sub_a, 4'h0);
    idle_chk(2);

    // Directed table: also checks the table constants against the long-division timing in run_op.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0);
      chk("tbl_q", quotient, vecs[i].q);
      chk("tbl_r", remainder, vecs[i].r);
      chk("tbl_dz", div_by_zero, vecs[i].dz);
      idle_chk(2);
    end

    // Start and operand changes during RUN must not disturb 12/5 or spawn a second op.
    run_op(4'd12, 4'd5, 1'b1);
    chk("rej_q", quotient, 4'd2);
    chk("rej_r", remainder, 4'd2);
    idle_chk(8);

    // Reset in the second RUN cycle aborts silently.
    dividend = 4'd11; divisor = 4'd2; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_q", quotient, 4'h0);
    chk("abort_r", remainder, 4'h0);
    last_q = 4'h0; last_r = 4'h0; last_dz = 1'b0;
    idle_chk(8);
    run_op(4'd10, 4'd3, 1'b0);
    idle_chk(1);

    // Reset wins over a simultaneous start.
    dividend = 4'd9; divisor = 4'd4; start = 1'b1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; rst = 1'b0;
    chk("rst_start_busy", busy, 1'b0);
    last_q = 4'h0; last_r = 4'h0; last_dz = 1'b0;
    idle_chk(3);

    // Exhaustive, back-to-back: each start is raised in the cycle done is high.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(4'(a), 4'(b), 1'b0);
    idle_chk(1);

    // Random operands with random idle gaps.
    for (int n = 0; n < 60; n++) begin
      run_op(4'($urandom_range(15)), 4'($urandom_range(15)), 1'b0);
      idle_chk(int'($urandom_range(3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sub_div_ctrl.md
Name: sub_div_ctrl

Overview:
- Sequencing controller that computes a 4-bit unsigned restoring division (quotient and remainder) by driving one external 4-bit subtractor instance for four iterations.
- Sits beside the ALU subtractor in the 4-bit ALU. It owns the subtractor's operand inputs while busy and reads its difference and borrow outputs.
- The subtractor is purely combinational, so each iteration completes in one clock.

Parameters:
- None. Width is fixed at 4 bits to match the subtractor. The iteration count is fixed at 4.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a division; sampled only in IDLE
- dividend  input  4  unsigned dividend; captured when start is accepted
- divisor  input  4  unsigned divisor; captured when start is accepted
- sub_a  output  4  minuend driven to the external subtractor
- sub_b  output  4  subtrahend driven to the external subtractor
- sub_diff  input  4  difference returned by the subtractor (sub_a - sub_b, mod 16)
- sub_borrow  input  1  subtractor borrow; 1 means sub_a < sub_b
- busy  output  1  high while in RUN or DONE
- done  output  1  one-cycle pulse when results are valid
- quotient  output  4  result quotient
- remainder  output  4  result remainder
- div_by_zero  output  1  high with done when divisor was 0; held until next accept

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- On rst: state returns to IDLE; busy, done and div_by_zero go to 0; quotient and remainder go to 4'h0; iteration counter goes to 0. A reset mid-operation aborts the division and no done is produced.
- Internal registers: Q (4 bits), R (4 bits), D (4 bits), cnt (2 bits).
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge latches D=divisor, Q=dividend, R=0, cnt=0, clears div_by_zero.
  - Next state is RUN, or DONE if divisor==0.
  - start=0: remain in IDLE; outputs hold their previous results.
- RUN, each cycle:
  - low = {R[2:0], Q[3]}; hi = R[3].
  - sub_a = low, sub_b = D.
  - If hi | ~sub_borrow: R <= sub_diff, qbit = 1. Otherwise R <= low, qbit = 0.
  - Q <= {Q[2:0], qbit}; cnt <= cnt + 1.
  - After the 4th iteration (cnt==3) go to DONE.
  - hi is kept for correctness. R cannot reach 8 before the final shift for 4-bit operands, so hi is 0 in practice.
- Outputs on DONE entry:
  - quotient = Q, remainder = R, done = 1 for exactly one cycle, then return to IDLE.
  - Divide-by-zero path: quotient = 4'hF, remainder = latched dividend, div_by_zero = 1.
- Operand drive: in IDLE and DONE, sub_a and sub_b are driven as 4'h0. They are combinational from state and registers.
- Latency:
  - Start accepted at edge k: done is high during the cycle after edge k+5 (4 RUN cycles plus the DONE entry edge).
  - Divide-by-zero: done is high the cycle after edge k+1.
- start while busy (RUN or DONE) is ignored; no queuing.
- Input stability: changes on dividend and divisor after acceptance have no effect on the operation in progress.
- quotient, remainder and div_by_zero hold stable from done until the next accepted start. They are then updated only at the next DONE.
- Back-to-back: start high in the cycle after done (state IDLE) is accepted normally.
- rst and start both high in the same cycle: rst wins.

Test Plan:
- Basic: reset, then dividend=13, divisor=4, start pulse -> busy for 5 cycles; done pulse with quotient=3, remainder=1, div_by_zero=0.
- Extremes: 15/1 -> q=15, r=0. 15/15 -> q=1, r=0. 3/9 -> q=0, r=3. 0/5 -> q=0, r=0. Each gives done exactly 5 cycles after acceptance.
- Divide by zero: dividend=7, divisor=0 -> done on the 2nd cycle, quotient=4'hF, remainder=7, div_by_zero=1. The next valid op (8/3) clears div_by_zero and gives q=2, r=2.
- Busy rejection: start 12/5, then pulse start with 9/2 during RUN, and change the dividend/divisor inputs -> only one done, with q=2, r=2.
- Reset mid-operation: assert rst in the 2nd RUN cycle -> next cycle busy=0, done never pulses, quotient=remainder=0. A subsequent 10/3 gives q=3, r=1.
- Exhaustive: all 256 dividend/divisor pairs, issued back-to-back -> match a reference model. During RUN, sub_a and sub_b always equal {R[2:0], Q[3]} and D; in IDLE they are 0.
